// File: rtl/priority_event_encoder.sv
// -----------------------------------------------------------------------------
// priority_event_encoder
//
// Registered event front-end. It catches rising edges on N request lines in
// sticky pending bits and presents one pending index at a time on a
// valid/ready port. An accepted index clears its pending bit. The selection
// policy is fixed at build time:
//   RR_MODE = 0 : fixed priority, highest set index wins.
//   RR_MODE = 1 : round-robin. The search runs downward with wrap, starting
//                 just below the last accepted index.
//
// Parameters
//   N        number of request lines (2..64)
//   RR_MODE  0 = fixed priority, 1 = round-robin
//   W        index width, derived from N (localparam)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, overrides every other input
//   req_in     in   [N]  request lines; a 0->1 transition registers one event
//   clear_all  in   synchronous flush of pending bits, out_valid and overflow
//   out_ready  in   consumer takes out_idx this cycle
//   out_valid  out  out_idx holds a pending event
//   out_idx    out  [W]  index being presented
//   pending    out  [N]  sticky pending bits
//   overflow   out  sticky: an edge arrived on a bit that was already pending
//
// Every output is driven straight from a register. No input reaches an
// output through combinational logic.
// -----------------------------------------------------------------------------
module priority_event_encoder #(
  parameter int N       = 8,
  parameter bit RR_MODE = 1'b0,
  localparam int W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         clear_all,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  // Highest set index of p. Returns 0 when p is empty; the caller does not
  // use the result in that case.
  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] p);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) s = W'(i);
    end
    return s;
  endfunction

  // Round-robin pick. The search visits from-1, from-2, ... with wrap and ends
  // on 'from' itself. The loop runs from the farthest candidate (k = N) to the
  // nearest (k = 1). The last hit to be written is therefore the first one in
  // search order.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] p,
                                          input logic [W-1:0] from);
    logic [W-1:0] s;
    logic [W-1:0] pos;
    s = '0;
    for (int k = N; k >= 1; k--) begin
      pos = W'((int'(from) + N - k) % N);
      if (p[pos]) s = pos;
    end
    return s;
  endfunction

  logic [N-1:0] req_q;
  logic         armed;
  logic [W-1:0] last;

  logic [N-1:0] rise;
  logic         acc;
  logic [N-1:0] acc_mask;
  logic [N-1:0] pending_next;
  logic         overflow_next;
  logic [W-1:0] last_next;
  logic [W-1:0] sel;
  logic         hold;

  // ---- next-state: edge detect, pending update, selection ----
  always_comb begin
    // armed is low for the first cycle after reset. A line that is still high
    // when reset is released is loaded into req_q as a level, and it does not
    // count as a fresh edge.
    rise = req_in & ~req_q & {N{armed}};
    acc  = out_valid & out_ready;

    acc_mask = '0;
    if (acc) acc_mask[out_idx] = 1'b1;

    // A new edge takes priority over an accept of the same bit. The event is
    // then presented again, and it does not count as an overflow.
    if (clear_all) begin
      pending_next  = '0;
      overflow_next = 1'b0;
    end else begin
      pending_next  = (pending & ~acc_mask) | rise;
      overflow_next = overflow | (|(rise & pending & ~acc_mask));
    end

    // The pointer moves in the same cycle as the accept. This lets the pick
    // made in this cycle start just below the index that was just taken.
    last_next = acc ? out_idx : last;

    if (RR_MODE) sel = sel_rr(pending_next, last_next);
    else         sel = sel_fixed(pending_next);

    // While an offer is outstanding it stays stable, even if a higher-priority
    // event arrives in the meantime.
    hold = out_valid & ~out_ready & ~clear_all;
  end

  // ---- state / output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      armed     <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
      last      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      req_q    <= req_in;
      armed    <= 1'b1;
      pending  <= pending_next;
      overflow <= overflow_next;
      last     <= last_next;
      if (!hold) begin
        out_valid <= |pending_next;
        // When nothing is pending, out_idx keeps its last value.
        if (|pending_next) out_idx <= sel;
      end
    end
  end

endmodule

// File: tb/tb_priority_event_encoder.sv
// -----------------------------------------------------------------------------
// Bench for priority_event_encoder. It builds three instances:
//   A : N=8, fixed priority   (table of vectors plus a held-level sequence)
//   B : N=8, round-robin      (accept sequence with a mid-stream new edge)
//   C : N=5, round-robin      (single-bit mapping and pointer wrap)
// Inputs change on the falling edge. Outputs are sampled 1ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_priority_event_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: N=8 fixed ----------------
  logic       a_rst = 1'b1, a_clr = 1'b0, a_rdy = 1'b0;
  logic [7:0] a_req = '0;
  logic       a_vld, a_ovf;
  logic [2:0] a_idx;
  logic [7:0] a_pnd;

  priority_event_encoder #(.N(8), .RR_MODE(1'b0)) dut_a (
    .clk(clk), .rst(a_rst), .req_in(a_req), .clear_all(a_clr),
    .out_ready(a_rdy), .out_valid(a_vld), .out_idx(a_idx),
    .pending(a_pnd), .overflow(a_ovf)
  );

  // ---------------- instance B: N=8 round-robin ----------------
  logic       b_rst = 1'b1, b_clr = 1'b0, b_rdy = 1'b0;
  logic [7:0] b_req = '0;
  logic       b_vld, b_ovf;
  logic [2:0] b_idx;
  logic [7:0] b_pnd;

  priority_event_encoder #(.N(8), .RR_MODE(1'b1)) dut_b (
    .clk(clk), .rst(b_rst), .req_in(b_req), .clear_all(b_clr),
    .out_ready(b_rdy), .out_valid(b_vld), .out_idx(b_idx),
    .pending(b_pnd), .overflow(b_ovf)
  );

  // ---------------- instance C: N=5 round-robin ----------------
  logic       c_rst = 1'b1, c_clr = 1'b0, c_rdy = 1'b0;
  logic [4:0] c_req = '0;
  logic       c_vld, c_ovf;
  logic [2:0] c_idx;
  logic [4:0] c_pnd;

  priority_event_encoder #(.N(5), .RR_MODE(1'b1)) dut_c (
    .clk(clk), .rst(c_rst), .req_in(c_req), .clear_all(c_clr),
    .out_ready(c_rdy), .out_valid(c_vld), .out_idx(c_idx),
    .pending(c_pnd), .overflow(c_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic r, input logic c, input logic y,
                         input logic [7:0] q);
    @(negedge clk);
    a_rst = r; a_clr = c; a_rdy = y; a_req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic r, input logic y, input logic [7:0] q);
    @(negedge clk);
    b_rst = r; b_clr = 1'b0; b_rdy = y; b_req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic r, input logic y, input logic [4:0] q);
    @(negedge clk);
    c_rst = r; c_clr = 1'b0; c_rdy = y; c_req = q;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       clr;
    logic       rdy;
    logic [7:0] req;
    logic       vld;
    logic [2:0] idx;
    logic [7:0] pnd;
    logic       ovf;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic c, input logic y,
                              input logic [7:0] q, input logic v,
                              input logic [2:0] i, input logic [7:0] p,
                              input logic o);
    vec_t t;
    t.rst = r; t.clr = c; t.rdy = y; t.req = q;
    t.vld = v; t.idx = i; t.pnd = p; t.ovf = o;
    return t;
  endfunction

  typedef struct {
    logic [7:0] req;
    logic       vld;
    logic [2:0] idx;
    logic [7:0] pnd;
  } rr_t;

  vec_t tbl[$];
  rr_t  rrb[$];

  initial begin
    int   events;
    rr_t  r;

    //        rst clr rdy req    | vld idx pnd    ovf
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0)); // reset
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 8'h84, 1, 7, 8'h84, 0)); // two edges, 7 wins
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 8'h00, 1, 7, 8'h84, 0)); // held, not ready
    tbl.push_back(mk(0, 0, 1, 8'h00, 1, 2, 8'h04, 0)); // 7 accepted
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 2, 8'h00, 0)); // 2 accepted, idx holds
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 2, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 8'h08, 1, 3, 8'h08, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3, 8'h08, 0));
    tbl.push_back(mk(0, 0, 1, 8'h08, 1, 3, 8'h08, 0)); // edge + accept same bit
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3, 8'h08, 0));
    tbl.push_back(mk(0, 0, 0, 8'h08, 1, 3, 8'h08, 1)); // edge on pending -> ovf
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 3, 8'h00, 1)); // ovf sticky
    tbl.push_back(mk(0, 0, 0, 8'h0A, 1, 3, 8'h0A, 1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 3, 8'h00, 0)); // clear_all
    tbl.push_back(mk(0, 1, 0, 8'h80, 0, 3, 8'h00, 0)); // edge discarded
    tbl.push_back(mk(0, 0, 0, 8'h80, 0, 3, 8'h00, 0)); // req_q already high
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 8'h24, 1, 5, 8'h24, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 5, 8'h24, 0));
    tbl.push_back(mk(0, 0, 0, 8'h20, 1, 5, 8'h24, 1));
    tbl.push_back(mk(1, 0, 0, 8'h20, 0, 0, 8'h00, 0)); // rst mid-burst
    tbl.push_back(mk(0, 0, 0, 8'h20, 0, 0, 8'h00, 0)); // held through release
    tbl.push_back(mk(0, 0, 0, 8'h20, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 8'h20, 1, 5, 8'h20, 0)); // fresh rise counts
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 5, 8'h20, 0));
    tbl.push_back(mk(0, 0, 0, 8'h80, 1, 5, 8'hA0, 0)); // offer holds vs higher
    tbl.push_back(mk(0, 0, 1, 8'h00, 1, 7, 8'h80, 0));
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 7, 8'h00, 0));

    //            req    vld idx pnd    (B, ready=1 throughout)
    r = '{8'h00, 1'b1, 3'd6, 8'h7F}; rrb.push_back(r);
    r = '{8'h00, 1'b1, 3'd5, 8'h3F}; rrb.push_back(r);
    r = '{8'h80, 1'b1, 3'd4, 8'h9F}; rrb.push_back(r); // bit 7 edge as 5 accepted
    r = '{8'h00, 1'b1, 3'd3, 8'h8F}; rrb.push_back(r);
    r = '{8'h00, 1'b1, 3'd2, 8'h87}; rrb.push_back(r);
    r = '{8'h00, 1'b1, 3'd1, 8'h83}; rrb.push_back(r);
    r = '{8'h00, 1'b1, 3'd0, 8'h81}; rrb.push_back(r);
    r = '{8'h00, 1'b1, 3'd7, 8'h80}; rrb.push_back(r);
    r = '{8'h00, 1'b0, 3'd7, 8'h00}; rrb.push_back(r);

    // ---------------- A: table ----------------
    foreach (tbl[i]) begin
      drive_a(tbl[i].rst, tbl[i].clr, tbl[i].rdy, tbl[i].req);
      chk($sformatf("A[%0d] out_valid", i), 64'(a_vld), 64'(tbl[i].vld));
      chk($sformatf("A[%0d] out_idx", i),   64'(a_idx), 64'(tbl[i].idx));
      chk($sformatf("A[%0d] pending", i),   64'(a_pnd), 64'(tbl[i].pnd));
      chk($sformatf("A[%0d] overflow", i),  64'(a_ovf), 64'(tbl[i].ovf));
    end

    // ---------------- A: level held high for 20 cycles ----------------
    events = 0;
    for (int i = 0; i < 20; i++) begin
      drive_a(1'b0, 1'b0, 1'b1, 8'h02);
      if (a_vld) begin
        events++;
        chk("A held idx", 64'(a_idx), 64'd1);
      end
    end
    chk("A held event count", 64'(events), 64'd1);
    chk("A held pending", 64'(a_pnd), 64'h00);
    chk("A held overflow", 64'(a_ovf), 64'd0);

    // ---------------- B: round-robin ----------------
    drive_b(1'b1, 1'b0, 8'h00);
    chk("B reset valid", 64'(b_vld), 64'd0);
    chk("B reset pending", 64'(b_pnd), 64'h00);
    drive_b(1'b0, 1'b0, 8'h00);
    drive_b(1'b0, 1'b0, 8'hFF);
    chk("B first valid", 64'(b_vld), 64'd1);
    chk("B first idx", 64'(b_idx), 64'd7);
    chk("B first pending", 64'(b_pnd), 64'hFF);
    foreach (rrb[i]) begin
      drive_b(1'b0, 1'b1, rrb[i].req);
      chk($sformatf("B[%0d] out_valid", i), 64'(b_vld), 64'(rrb[i].vld));
      chk($sformatf("B[%0d] out_idx", i),   64'(b_idx), 64'(rrb[i].idx));
      chk($sformatf("B[%0d] pending", i),   64'(b_pnd), 64'(rrb[i].pnd));
    end
    chk("B overflow", 64'(b_ovf), 64'd0);

    // ---------------- C: N=5 round-robin ----------------
    drive_c(1'b1, 1'b0, 5'h00);
    chk("C reset valid", 64'(c_vld), 64'd0);
    drive_c(1'b0, 1'b0, 5'h00);
    for (int b = 0; b < 5; b++) begin
      drive_c(1'b0, 1'b0, 5'(1 << b));
      chk($sformatf("C single %0d valid", b), 64'(c_vld), 64'd1);
      chk($sformatf("C single %0d idx", b), 64'(c_idx), 64'(b));
      chk($sformatf("C single %0d pending", b), 64'(c_pnd), 64'(1 << b));
      drive_c(1'b0, 1'b1, 5'h00);
      chk($sformatf("C single %0d drained", b), 64'(c_vld), 64'd0);
    end
    // last = 4 now, so the search starts at 3
    drive_c(1'b0, 1'b0, 5'h1F);
    chk("C rr start idx", 64'(c_idx), 64'd3);
    chk("C rr start pending", 64'(c_pnd), 64'h1F);
    drive_c(1'b0, 1'b1, 5'h00);
    chk("C rr idx 2", 64'(c_idx), 64'd2);
    drive_c(1'b0, 1'b1, 5'h00);
    chk("C rr idx 1", 64'(c_idx), 64'd1);
    drive_c(1'b0, 1'b1, 5'h00);
    chk("C rr idx 0", 64'(c_idx), 64'd0);
    chk("C rr pending 11", 64'(c_pnd), 64'h11);
    drive_c(1'b0, 1'b1, 5'h00);
    chk("C wrap idx", 64'(c_idx), 64'd4);
    chk("C wrap valid", 64'(c_vld), 64'd1);
    chk("C wrap pending", 64'(c_pnd), 64'h10);
    drive_c(1'b0, 1'b1, 5'h00);
    chk("C final valid", 64'(c_vld), 64'd0);
    chk("C final pending", 64'(c_pnd), 64'h00);
    chk("C overflow", 64'(c_ovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
